// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-to-decode handshake bundle: head instruction, its successor PC,
// valid from the fetch side and ready from the decode side.
//   master (fetch):  drives valid, instruction, pc_next; samples dec_ready
//   slave (decode):  samples valid, instruction, pc_next; drives dec_ready
interface fetch_prefetch_unit_if #(
    parameter int NB_INST = 32,
    parameter int NB_ADDR = 32
);
    logic               valid;
    logic [NB_INST-1:0] instruction;
    logic [NB_ADDR-1:0] pc_next;
    logic               dec_ready;

    modport master (
        output valid,
        output instruction,
        output pc_next,
        input  dec_ready
    );

    modport slave (
        input  valid,
        input  instruction,
        input  pc_next,
        output dec_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// IF stage: debug-loaded instruction memory, PC, credit-based prefetch FIFO
// feeding ID, redirect flush and HALT detection with drain.
//   i_clk, i_reset (sync, active-low), i_enable (freeze when 0)
//   i_debug_unit/i_mem_wen/i_wr_addr/i_mem_data: debug memory load port
//   i_redirect/i_redirect_addr: flush and restart fetch at target
//   id_bus (master): FWFT head valid/instruction/pc_next, dec_ready from ID
//   o_fetch_pc: next address to issue, o_halted: HALT reached and drained
module fetch_prefetch_unit #(
    parameter int         NB_INST    = 32,
    parameter int         NB_ADDR    = 32,
    parameter int         MEM_DEPTH  = 64,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] HALT_OP    = 6'b111111
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_debug_unit,
    input  logic               i_mem_wen,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_INST-1:0] i_mem_data,
    input  logic               i_redirect,
    input  logic [NB_ADDR-1:0] i_redirect_addr,
    fetch_prefetch_unit_if.master id_bus,
    output logic [NB_ADDR-1:0] o_fetch_pc,
    output logic               o_halted
);
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [NB_ADDR-1:0] MEM_LIMIT = NB_ADDR'(MEM_DEPTH);
    localparam logic [CW-1:0]      FIFO_CAP  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t state, state_d;

    logic [NB_INST-1:0] mem       [MEM_DEPTH];
    logic [NB_INST-1:0] fifo_inst [FIFO_DEPTH];
    logic [NB_ADDR-1:0] fifo_pc   [FIFO_DEPTH];

    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      occupancy;
    logic [NB_ADDR-1:0] pc, rd_pc;
    logic [NB_INST-1:0] rd_data, mem_rd;
    logic               inflight;

    logic active, empty, leave_debug, do_redirect;
    logic do_push, halt_push, do_pop, do_issue, mem_write;

    assign active      = (state == RUN) || (state == DRAIN);
    assign empty       = (count == '0);
    assign leave_debug = i_enable && i_debug_unit
                       && ((state == DRAIN) || (state == HALTED));
    assign do_redirect = i_enable && i_redirect && active && !leave_debug;

    // Words still in flight after a HALT push land in DRAIN and are dropped.
    assign do_push   = i_enable && inflight && (state == RUN)
                     && !do_redirect;
    assign halt_push = do_push && (rd_data[NB_INST-1 -: 6] == HALT_OP);
    assign do_pop    = i_enable && !empty && id_bus.dec_ready && active
                     && !do_redirect;

    // Credit counts the in-flight read; a same-cycle pop frees nothing yet.
    assign occupancy = count + CW'(inflight);
    assign do_issue  = i_enable && (state == RUN) && (occupancy < FIFO_CAP)
                     && !halt_push && !do_redirect;

    assign mem_write = (state == IDLE) && i_debug_unit && i_mem_wen
                     && (i_wr_addr < MEM_LIMIT);
    assign mem_rd    = (pc < MEM_LIMIT) ? mem[pc[MAW-1:0]] : '0;

    always_ff @(posedge i_clk) begin
        if (mem_write)
            mem[i_wr_addr[MAW-1:0]] <= i_mem_data;
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            fifo_inst[wr_ptr] <= rd_data;
            fifo_pc[wr_ptr]   <= rd_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:
                if (i_enable && !i_debug_unit)
                    state_d = RUN;
            RUN:
                if (!do_redirect && halt_push)
                    state_d = DRAIN;
            DRAIN:
                if (leave_debug)
                    state_d = IDLE;
                else if (do_redirect)
                    state_d = RUN;
                else if (i_enable && empty)
                    state_d = HALTED;
            HALTED:
                if (leave_debug)
                    state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pc       <= '0;
            rd_pc    <= '0;
            rd_data  <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (leave_debug || do_redirect) begin
            pc       <= leave_debug ? '0 : i_redirect_addr;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (do_issue) begin
                pc       <= pc + NB_ADDR'(1);
                rd_pc    <= pc;
                rd_data  <= mem_rd;
                inflight <= 1'b1;
            end else if (i_enable) begin
                inflight <= 1'b0;
            end
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    assign id_bus.valid       = !empty;
    assign id_bus.instruction = empty ? '0 : fifo_inst[rd_ptr];
    assign id_bus.pc_next     = empty ? '0 : fifo_pc[rd_ptr] + NB_ADDR'(1);
    assign o_fetch_pc         = pc;
    assign o_halted           = (state == HALTED);
endmodule
